// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : Shared widths and block type for the DES datapath.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;
    localparam int DEF_HALF_W = 32;
    localparam int BLOCK_W    = 64;

    typedef logic [BLOCK_W-1:0] block_t;
endpackage
`default_nettype wire

// File: rtl/output_assembler_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, registered storage, head word always visible.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule
`default_nettype wire

// File: rtl/output_assembler.sv
`default_nettype none
// ============================================================================
// Module   : output_assembler
// Brief    : Captures final round halves, applies the final swap and buffers
//            the block for a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module output_assembler
    import des_pkg::*;
#(
    parameter int HALF_W = DEF_HALF_W,
    parameter bit SWAP   = 1'b1,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done,
    input  logic [HALF_W-1:0]       left_in,
    input  logic [HALF_W-1:0]       right_in,
    output logic                    ready_out,
    output logic [2*HALF_W-1:0]     data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    logic [2*HALF_W-1:0] wr_word;
    logic                full, empty, push, pop;
    logic                overflow_q;

    generate
        if (SWAP) begin : g_swap
            assign wr_word = {right_in, left_in};
        end else begin : g_noswap
            assign wr_word = {left_in, right_in};
        end
    endgenerate

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop  = valid_out && ready_in;
    assign push = done && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst)                        overflow_q <= 1'b0;
        else if (done && full && !pop)  overflow_q <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (2*HALF_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_word),
        .rdata_o (data_out),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign valid_out = !empty;
    assign ready_out = !full;
    assign overflow  = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_output_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_assembler
// Brief    : Scoreboard bench for output_assembler, SWAP=1 and SWAP=0 copies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_assembler;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b0;
    logic        ready_in = 1'b1;
    logic [31:0] left_in = '0;
    logic [31:0] right_in = '0;

    logic        ready1, valid1, ovf1, ready0, valid0, ovf0;
    logic [63:0] data1, data0;
    logic [1:0]  count1, count0;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    logic        exp_ovf = 1'b0;
    bit          chk_en = 1'b0;
    int          rcvd = 0;

    always #5 clk = ~clk;

    output_assembler #(.HALF_W(32), .SWAP(1'b1), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .done(done), .left_in(left_in), .right_in(right_in),
        .ready_out(ready1), .data_out(data1), .valid_out(valid1), .ready_in(ready_in),
        .count(count1), .overflow(ovf1)
    );

    output_assembler #(.HALF_W(32), .SWAP(1'b0), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .done(done), .left_in(left_in), .right_in(right_in),
        .ready_out(ready0), .data_out(data0), .valid_out(valid0), .ready_in(ready_in),
        .count(count0), .overflow(ovf0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model step, evaluated on the inputs the next rising edge will see.
    task automatic sb_step();
        int  n;
        bit  sb_pop, sb_push;
        n = q1.size();
        chk("valid1", valid1, n != 0);
        chk("valid0", valid0, n != 0);
        chk("count1", count1, n);
        chk("count0", count0, n);
        chk("ready_out", ready1, n < DEPTH);
        chk("overflow1", ovf1, exp_ovf);
        chk("overflow0", ovf0, exp_ovf);
        if (rst) begin
            q1.delete();
            q0.delete();
            exp_ovf = 1'b0;
        end else begin
            sb_pop  = (n != 0) && ready_in;
            sb_push = done && ((n < DEPTH) || sb_pop);
            if (sb_pop) begin
                chk("data1", data1, q1.pop_front());
                chk("data0", data0, q0.pop_front());
                rcvd++;
            end
            if (sb_push) begin
                q1.push_back({right_in, left_in});
                q0.push_back({left_in, right_in});
            end
            if (done && !sb_push) exp_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r);
        done = 1'b1; left_in = l; right_in = r;
        tick();
        done = 1'b0;
    endtask

    initial begin
        int sent, cyc, r0;

        tick();
        tick();
        chk("rst_valid", valid1, 0);
        chk("rst_data", data1, 64'h0);
        chk("rst_count", count1, 0);
        chk("rst_ready", ready1, 1);
        chk("rst_ovf", ovf1, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single block, swapped and unswapped
        ready_in = 1'b1;
        send(32'h01234567, 32'h89ABCDEF);
        chk("t1_valid", valid1, 1);
        chk("t1_data_swap", data1, 64'h89ABCDEF01234567);
        chk("t2_data_noswap", data0, 64'h0123456789ABCDEF);
        tick();
        chk("t1_valid_after", valid1, 0);
        chk("t1_count_after", count1, 0);

        // Backpressure: two entries held, head stable
        ready_in = 1'b0;
        send(32'h11111111, 32'h22222222);
        send(32'h33333333, 32'h44444444);
        chk("t3_count", count1, 2);
        chk("t3_ready_out", ready1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_data", data1, 64'h2222222211111111);
            tick();
        end
        ready_in = 1'b1;
        tick();
        chk("t3_second", data1, 64'h4444444433333333);
        tick();
        chk("t3_drained", count1, 0);

        // Overflow when full without pop, then full with pop
        ready_in = 1'b0;
        send(32'hC0C0C0C0, 32'hC1C1C1C1);
        send(32'hD0D0D0D0, 32'hD1D1D1D1);
        send(32'hE0E0E0E0, 32'hE1E1E1E1);
        chk("t4_ovf", ovf1, 1);
        chk("t4_count", count1, 2);
        chk("t4_head", data1, 64'hC1C1C1C1C0C0C0C0);
        ready_in = 1'b1;
        send(32'hF0F0F0F0, 32'hF1F1F1F1);
        ready_in = 1'b0;
        chk("t4_count_pp", count1, 2);
        chk("t4_ovf_sticky", ovf1, 1);
        chk("t4_head_pp", data1, 64'hD1D1D1D1D0D0D0D0);
        ready_in = 1'b1;
        tick();
        chk("t4_tail", data1, 64'hF1F1F1F1F0F0F0F0);
        tick();
        chk("t4_drained", count1, 0);

        // Reset mid-operation with a coincident done
        ready_in = 1'b0;
        send(32'h0A0A0A0A, 32'h0B0B0B0B);
        send(32'h0C0C0C0C, 32'h0D0D0D0D);
        chk("t5_count_pre", count1, 2);
        rst = 1'b1;
        send(32'h0E0E0E0E, 32'h0F0F0F0F);
        rst = 1'b0;
        chk("t5_valid", valid1, 0);
        chk("t5_data", data1, 64'h0);
        chk("t5_count", count1, 0);
        chk("t5_ovf", ovf1, 0);
        chk("t5_ready", ready1, 1);

        // Random streams, done gated by ready_out
        sent = 0;
        cyc = 0;
        r0 = rcvd;
        while (sent < 1000 && cyc < 20000) begin
            done     = ready1 && ($urandom_range(0, 9) < 6);
            left_in  = $urandom;
            right_in = $urandom;
            ready_in = ($urandom_range(0, 1) == 1);
            if (done) sent++;
            tick();
            cyc++;
        end
        done = 1'b0;
        ready_in = 1'b1;
        cyc = 0;
        while (q1.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        chk("t6_sent", sent, 1000);
        chk("t6_received", rcvd - r0, 1000);
        chk("t6_sb_empty", q1.size(), 0);
        chk("t6_ovf", ovf1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/output_assembler.md
Name: output_assembler

Overview:
Output-side counterpart to the block-input splitter. It captures the 32-bit left/right halves produced by the round engine on its completion pulse and applies the final half swap. The resulting 64-bit block is buffered in a small FIFO and presented to the downstream consumer over a valid/ready handshake. It sits between the final Feistel round and the ciphertext/plaintext sink, and absorbs downstream backpressure.

Parameters:
HALF_W, 32, width of each half; the output is 2*HALF_W.
SWAP, 1, 1 = output {right_in, left_in} (DES final swap before FP); 0 = output {left_in, right_in}.
DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  rising-edge clock; the only clock.
rst  in  1  synchronous, active-high reset.
done  in  1  single-cycle completion pulse from the round engine; halves are valid in this cycle.
left_in  in  HALF_W  left half after the last round.
right_in  in  HALF_W  right half after the last round.
ready_out  out  1  upstream may pulse done; equals !full.
data_out  out  2*HALF_W  head-of-FIFO block.
valid_out  out  1  data_out holds a valid block.
ready_in  in  1  downstream accepts data_out this cycle.
count  out  $clog2(DEPTH)+1  entries currently held.
overflow  out  1  sticky: a done pulse arrived and was dropped.

Behaviour:
- Reset: synchronous on posedge clk while rst=1. Storage cleared to 0, data_out=0, valid_out=0, count=0, ready_out=1, overflow=0. Reset mid-operation discards every buffered entry; a done pulse in the same cycle as rst is ignored.
- push = done && (count<DEPTH || pop); pop = valid_out && ready_in.
- Write word: SWAP=1 gives {right_in,left_in}; SWAP=0 gives {left_in,right_in}. The write pointer wraps modulo DEPTH.
- Latency: done at edge N makes valid_out=1 with the new word on data_out after edge N+1, when the FIFO was empty. Bypass from done to data_out in the same cycle is not allowed.
- data_out and valid_out are driven from registered storage and pointers only. data_out holds stable while valid_out && !ready_in.
- count update: count+1 on push without pop; count-1 on pop without push; unchanged on both or neither.
- Full with simultaneous done and pop: the push is accepted, count stays DEPTH, and the read and write pointers both advance.
- Full with done and no pop: the word is dropped, overflow latches to 1 and clears only on rst. FIFO contents are unchanged.
- Empty with ready_in=1: no pop, and pointers are unchanged.
- Ordering is strict FIFO; no entry is reordered or duplicated.
- done high on consecutive cycles is legal; each high cycle is a separate push.

Decomposition:
- Shared package (des_pkg): HALF_W default, BLOCK_W=64, and the block_t typedef (logic [63:0]).
- One natural sub-module: sync_fifo (parameterised width/depth, synchronous active-high reset, push/pop/full/empty/count).
- output_assembler holds the swap mux, the push/pop and overflow logic, and the sync_fifo instance.

Test Plan:
1. Reset, then done with left_in=0x01234567, right_in=0x89ABCDEF, SWAP=1, ready_in=1 -> next cycle valid_out=1, data_out=0x89ABCDEF01234567; following cycle valid_out=0, count=0.
2. SWAP=0, same halves -> data_out=0x0123456789ABCDEF.
3. ready_in=0; done with halves A=(0x11111111,0x22222222) then B=(0x33333333,0x44444444) -> count=2, ready_out=0. data_out stays 0x2222222211111111 over 5 stall cycles. Then ready_in=1 drains A then B in order; count ends at 0.
4. FIFO full, ready_in=0, third done -> overflow=1, count=2, contents unchanged. Repeat with ready_in=1 in the same cycle as done -> accepted, overflow unchanged, count=2.
5. Two entries buffered; assert rst for 1 cycle -> valid_out=0, data_out=0, count=0, overflow=0, ready_out=1. A done coincident with rst leaves count=0.
6. Random done/ready_in streams of 1000 blocks vs a scoreboard queue -> no loss (overflow stays 0 when done is gated by ready_out), no duplication, order preserved, and pointer wrap exercised.
